// File: rtl/encode_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined signed multiplier among NUM_REQ requesters.
// Define MUL_SCHED_PERF_EN to build the issue/stall performance counters.
module encode_mul_rr_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned DIN0_WIDTH = 40,
  parameter int unsigned DIN1_WIDTH = 31,
  parameter int unsigned DOUT_WIDTH = 70,
  parameter int unsigned MUL_LAT    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             mul_ce,
  output logic [DIN0_WIDTH-1:0]            mul_din0,
  output logic [DIN1_WIDTH-1:0]            mul_din1,
  input  logic [DOUT_WIDTH-1:0]            mul_dout,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  input  logic                             rsp_ready,
  output logic [31:0]                      perf_issue_cnt,
  output logic [31:0]                      perf_stall_cnt
);

  localparam int unsigned TagW = IDX_W + 1;

  logic [DIN0_WIDTH-1:0] din0_arr [NUM_REQ];
  logic [DIN1_WIDTH-1:0] din1_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din0_arr[i] = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
    assign din1_arr[i] = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
  end

  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        gnt_idx;
  logic [IDX_W:0]          cand;
  logic                    gnt_found;
  logic                    grant;
  // Tag pipeline {v, idx} per stage; stage 0 in the LSBs, last stage in the MSBs.
  logic [MUL_LAT*TagW-1:0] tag_q, tag_d;
  logic [TagW-1:0]         tag_last;

  assign tag_last = tag_q[MUL_LAT*TagW-1 -: TagW];
  assign mul_ce   = ~(tag_last[IDX_W] & ~rsp_ready);

  // Circular search starting at rr_ptr; cand never exceeds 2*NUM_REQ-2 so one subtract suffices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + TagW'(k);
      if (cand >= TagW'(NUM_REQ)) begin
        cand = cand - TagW'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign grant     = gnt_found & mul_ce & reset;
  assign rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign mul_din0  = din0_arr[gnt_idx];
  assign mul_din1  = din1_arr[gnt_idx];
  assign rsp_valid = tag_last[IDX_W] ? (NUM_REQ'(1) << tag_last[IDX_W-1:0]) : '0;
  assign rsp_dout  = mul_dout;

  if (MUL_LAT == 1) begin : g_tag_one
    assign tag_d = {grant, gnt_idx};
  end else begin : g_tag_multi
    assign tag_d = {tag_q[(MUL_LAT-1)*TagW-1:0], grant, gnt_idx};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      if (grant) begin
        rr_ptr_q <= rr_ptr_d;
      end
      if (mul_ce) begin
        tag_q <= tag_d;
      end
    end
  end

`ifdef MUL_SCHED_PERF_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (!mul_ce) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_encode_mul_rr_sched.sv
// Self-checking bench for encode_mul_rr_sched with a behavioural multiplier and a queue-based
// reference model of the scheduler.
module tb_encode_mul_rr_sched;

  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int W0  = 40;
  localparam int W1  = 31;
  localparam int WO  = 70;
`ifdef MUL_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*W0-1:0] req_din0;
  logic [N*W1-1:0] req_din1;
  logic            mul_ce, rsp_ready;
  logic [W0-1:0]   mul_din0;
  logic [W1-1:0]   mul_din1;
  logic [WO-1:0]   mul_dout, rsp_dout;
  logic [31:0]     perf_issue_cnt, perf_stall_cnt;

  logic [W0-1:0] a [N];
  logic [W1-1:0] b [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_din0[i*W0 +: W0] = a[i];
    assign req_din1[i*W1 +: W1] = b[i];
  end

  always #5 clk = ~clk;

  encode_mul_rr_sched #(
    .NUM_REQ(N), .IDX_W(2), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO), .MUL_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .rsp_ready(rsp_ready), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  // Behavioural pipelined signed multiplier with clock enable.
  logic [WO-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= $signed(mul_din0) * $signed(mul_din1);
      for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  // Reference model: FIFO of outstanding results, each aging by one per enabled cycle.
  typedef struct {
    int            idx;
    logic [WO-1:0] prod;
    int            age;
  } ent_t;

  ent_t          q[$];
  int            ptr, m_issue, m_stall, last_gnt, exp_gnt;
  logic          head_vis, exp_ce;
  logic [N-1:0]  exp_ready, exp_rsp_valid;
  logic [WO-1:0] exp_dout;
  int            n_tests = 0;
  int            n_fail = 0;

  function automatic logic [WO-1:0] ref_prod(logic [W0-1:0] x, logic [W1-1:0] y);
    logic signed [WO-1:0] sx, sy;
    sx = {{(WO-W0){x[W0-1]}}, x};
    sy = {{(WO-W1){y[W1-1]}}, y};
    return sx * sy;
  endfunction

  function automatic void model_eval();
    head_vis      = (q.size() > 0) && (q[0].age == LAT);
    exp_ce        = !(head_vis && !rsp_ready);
    exp_rsp_valid = head_vis ? (N'(1) << q[0].idx) : '0;
    exp_dout      = head_vis ? q[0].prod : '0;
    exp_gnt       = -1;
    if (exp_ce) begin
      for (int k = 0; k < N; k++) begin
        if (exp_gnt < 0 && req_valid[(ptr + k) % N]) exp_gnt = (ptr + k) % N;
      end
    end
    exp_ready = (exp_gnt >= 0) ? (N'(1) << exp_gnt) : '0;
  endfunction

  function automatic void model_commit();
    ent_t e;
    model_eval();
    if (head_vis && rsp_ready) void'(q.pop_front());
    if (exp_ce) begin
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (exp_gnt >= 0) begin
        e.idx  = exp_gnt;
        e.prod = ref_prod(a[exp_gnt], b[exp_gnt]);
        e.age  = 1;
        q.push_back(e);
        ptr = (exp_gnt + 1) % N;
        m_issue++;
      end
    end else begin
      m_stall++;
    end
    last_gnt = exp_gnt;
  endfunction

  function automatic void model_clear();
    q.delete();
    ptr      = 0;
    m_issue  = 0;
    m_stall  = 0;
    last_gnt = -1;
  endfunction

  always @(posedge clk) if (reset === 1'b1) model_commit();

  task automatic new_data(int i);
    a[i] = W0'({$urandom(), $urandom()});
    b[i] = W1'($urandom());
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) new_data(i);
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_req_ready: actual %b required 0000", req_ready);
    end
    n_tests++;
    if (rsp_valid !== '0) begin
      n_fail++; $display("FAIL reset_rsp_valid: actual %b required 0000", rsp_valid);
    end
    n_tests++;
    if (mul_ce !== 1'b1) begin
      n_fail++; $display("FAIL reset_mul_ce: actual %b required 1", mul_ce);
    end
    n_tests++;
    if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: actual %0d/%0d required 0/0", perf_issue_cnt, perf_stall_cnt);
    end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    a[2] = -40'sd3;
    b[2] = 31'sd7;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk); model_eval();
    n_tests++;
    if (req_ready !== 4'b0100 || req_ready !== exp_ready) begin
      n_fail++; $display("FAIL single_grant: actual %b required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); model_eval();
    n_tests++;
    if (rsp_valid !== 4'b0100) begin
      n_fail++; $display("FAIL single_rsp_valid: actual %b required 0100", rsp_valid);
    end
    n_tests++;
    if (rsp_dout !== -70'sd21 || rsp_dout !== exp_dout) begin
      n_fail++; $display("FAIL single_rsp_dout: actual %0h required %0h", rsp_dout, -70'sd21);
    end
    @(posedge clk); #1;
  endtask

  // rr_ptr is 3 after the single request to index 2.
  task automatic test_wrap();
    logic [N-1:0] want;
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); model_eval();
      want = (k == 1) ? 4'b0001 : 4'b1000;
      n_tests++;
      if (req_ready !== want) begin
        n_fail++; $display("FAIL wrap_grant%0d: actual %b required %b", k, req_ready, want);
      end
      n_tests++;
      if (rsp_valid !== exp_rsp_valid) begin
        n_fail++; $display("FAIL wrap_rsp%0d: actual %b required %b", k, rsp_valid, exp_rsp_valid);
      end
      @(posedge clk); #1;
      if (last_gnt >= 0) new_data(last_gnt);
    end
  endtask

  task automatic test_stream();
    logic [N-1:0] want;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); model_eval();
      want = N'(1) << (k % N);
      n_tests++;
      if (req_ready !== want) begin
        n_fail++; $display("FAIL stream_grant%0d: actual %b required %b", k, req_ready, want);
      end
      want = (k == 0) ? 4'b1000 : N'(1) << ((k - 1) % N);
      n_tests++;
      if (rsp_valid !== want || rsp_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL stream_rsp%0d: actual %b/%0h required %b/%0h", k, rsp_valid, rsp_dout,
                 want, exp_dout);
      end
      @(posedge clk); #1;
      if (last_gnt >= 0) new_data(last_gnt);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    req_valid = '1;
    s0 = m_stall;
    for (int k = 0; k < 9; k++) begin
      rsp_ready = !(k >= 2 && k < 5);
      @(negedge clk); model_eval();
      n_tests++;
      if (mul_ce !== exp_ce || req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL bp_issue%0d: actual ce=%b ready=%b required ce=%b ready=%b", k, mul_ce,
                 req_ready, exp_ce, exp_ready);
      end
      n_tests++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && rsp_dout !== exp_dout)) begin
        n_fail++;
        $display("FAIL bp_rsp%0d: actual %b/%0h required %b/%0h", k, rsp_valid, rsp_dout,
                 exp_rsp_valid, exp_dout);
      end
      if (!rsp_ready) begin
        n_tests++;
        if (mul_ce !== 1'b0 || req_ready !== '0 || rsp_valid === '0) begin
          n_fail++;
          $display("FAIL bp_hold%0d: actual ce=%b ready=%b rsp=%b required 0/0000/held", k,
                   mul_ce, req_ready, rsp_valid);
        end
      end
      @(posedge clk); #1;
      if (last_gnt >= 0) new_data(last_gnt);
    end
    @(negedge clk);
    n_tests++;
    if (perf_stall_cnt !== (PERF ? 32'(s0 + 3) : 32'd0)) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: actual %0d required %0d", perf_stall_cnt,
               PERF ? s0 + 3 : 0);
    end
    @(posedge clk); #1;
    if (last_gnt >= 0) new_data(last_gnt);
  endtask

  task automatic test_extremes();
    logic [WO-1:0] want [2];
    want[0] = 70'd1 << 69;
    want[1] = -70'sd549755813887;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 2; k++) begin
      a[0] = (k == 0) ? 40'h80_0000_0000 : 40'h7F_FFFF_FFFF;
      b[0] = (k == 0) ? 31'h4000_0000 : 31'h7FFF_FFFF;
      req_valid = 4'b0001;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0001) begin
        n_fail++; $display("FAIL extreme_grant%0d: actual %b required 0001", k, req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 4'b0001 || rsp_dout !== want[k]) begin
        n_fail++;
        $display("FAIL extreme_dout%0d: actual %b/%0h required 0001/%0h", k, rsp_valid,
                 rsp_dout, want[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random(int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1) == 1) begin
          new_data(i);
          req_valid[i] = 1'b1;
        end
      end
      @(negedge clk); model_eval();
      n_tests++;
      if (mul_ce !== exp_ce || req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_issue%0d: actual ce=%b ready=%b required ce=%b ready=%b", k, mul_ce,
                 req_ready, exp_ce, exp_ready);
      end
      n_tests++;
      if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && rsp_dout !== exp_dout)) begin
        n_fail++;
        $display("FAIL rand_rsp%0d: actual %b/%0h required %b/%0h", k, rsp_valid, rsp_dout,
                 exp_rsp_valid, exp_dout);
      end
      @(posedge clk); #1;
      if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (perf_issue_cnt !== (PERF ? 32'(m_issue) : 32'd0)) begin
      n_fail++;
      $display("FAIL rand_issue_cnt: actual %0d required %0d", perf_issue_cnt,
               PERF ? m_issue : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < N; i++) new_data(i);
    req_valid = 4'b0110;
    @(posedge clk); #2;
    reset = 1'b0;
    req_valid = '1;
    #1;
    model_clear();
    n_tests++;
    if (req_ready !== '0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: actual ready=%b rsp=%b required 0000/0000", req_ready,
               rsp_valid);
    end
    n_tests++;
    if (perf_issue_cnt !== 32'd0) begin
      n_fail++; $display("FAIL midreset_perf: actual %0d required 0", perf_issue_cnt);
    end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== '0) begin
        n_fail++; $display("FAIL midreset_spurious%0d: actual %b required 0000", k, rsp_valid);
      end
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_first_grant: actual %b required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 4'b0001 || rsp_dout !== ref_prod(a[0], b[0])) begin
      n_fail++;
      $display("FAIL midreset_first_rsp: actual %b/%0h required 0001/%0h", rsp_valid, rsp_dout,
               ref_prod(a[0], b[0]));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_stream();
    test_back_to_back();
    test_extremes();
    test_random(400);
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual time limit reached, required bench completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
